// File: rtl/controle_partida.sv
// -----------------------------------------------------------------------------
// controle_partida
// Top-level sequencer for the naval battle game. It enables the placement
// phase, waits for `ready`, then alternates attack turns between player 0 and
// player 1 (human or CPU). It issues each shot to the board-memory path,
// counts hits per player and declares the winner.
//
// Optional feature macro: TIRO_EXTRA_EN
//   defined   -> a non-final hit keeps `vez`, so the same player fires again
//   undefined -> `vez` toggles after every non-final shot
//
// Ports
//   clk           in   single clock, posedge
//   reset         in   asynchronous, active-low, clears every register
//   enable        in   1 = run, 0 = freeze all state (enter edges are lost)
//   mode          in   0 = player 1 is CPU, 1 = player 1 is human
//   enter         in   debounced pushbutton level, active-low
//   ready         in   placement finished (only looked at in PLACE)
//   shoot_ack     in   one-cycle pulse, shot resolved (only looked at in SHOOT)
//   hit           in   shot result, valid with shoot_ack
//   place_en      out  placement block enable
//   shoot_req     out  shot request
//   atirador      out  player who is shooting (valid in SHOOT)
//   vez           out  player whose turn it is
//   fase          out  state code (IDLE=0 .. GAME_OVER=5)
//   hits0/hits1   out  hits scored by player 0 / player 1
//   ultimo_acerto out  result of the last resolved shot
//   erro          out  one-cycle pulse when a shot timed out
//   game_over     out  game finished
//   vencedor      out  winner, valid while game_over = 1
//
// Shot handshake: shoot_req is high for every cycle the FSM sits in SHOOT and
// drops in the cycle after shoot_ack is seen. The shot transfers in the cycle
// where shoot_req and shoot_ack are both high. If no ack arrives within
// ACK_TIMEOUT cycles, the shot is a miss and erro pulses. An ack in the last
// allowed cycle is still accepted.
// -----------------------------------------------------------------------------
module controle_partida #(
    parameter int TOTAL_HITS  = 24,
    parameter int CPU_DELAY   = 16,
    parameter int ACK_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       mode,
    input  logic       enter,
    input  logic       ready,
    input  logic       shoot_ack,
    input  logic       hit,
    output logic       place_en,
    output logic       shoot_req,
    output logic       atirador,
    output logic       vez,
    output logic [2:0] fase,
    output logic [4:0] hits0,
    output logic [4:0] hits1,
    output logic       ultimo_acerto,
    output logic       erro,
    output logic       game_over,
    output logic       vencedor
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLACE     = 3'd1,
        S_TURN_WAIT = 3'd2,
        S_SHOOT     = 3'd3,
        S_RESULT    = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic       vez_q, vez_d;
    logic [7:0] timer_q, timer_d;
    logic [4:0] hits0_q, hits0_d;
    logic [4:0] hits1_q, hits1_d;
    logic       ultimo_q, ultimo_d;
    logic       erro_q, erro_d;
    logic       vencedor_q, vencedor_d;
    logic       enter_q, enter_prev_q;

    logic       enter_evt;
    logic       cpu_turn;
    logic [4:0] cur_hits;
    logic [4:0] nxt_hits;

    // The button sampler keeps running while frozen, so an edge that happens
    // during a freeze has already settled when enable returns and is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter_q      <= 1'b0;
            enter_prev_q <= 1'b0;
        end else begin
            enter_q      <= enter;
            enter_prev_q <= enter_q;
        end
    end

    assign enter_evt = enter_prev_q & ~enter_q;
    assign cpu_turn  = vez_q & ~mode;
    assign cur_hits  = vez_q ? hits1_q : hits0_q;
    // Saturating increment; the counter never passes TOTAL_HITS.
    assign nxt_hits  = (ultimo_q && (cur_hits != 5'(TOTAL_HITS))) ? cur_hits + 5'd1 : cur_hits;

    always_comb begin
        state_d    = state_q;
        vez_d      = vez_q;
        timer_d    = timer_q;
        hits0_d    = hits0_q;
        hits1_d    = hits1_q;
        ultimo_d   = ultimo_q;
        erro_d     = 1'b0;
        vencedor_d = vencedor_q;

        case (state_q)
            S_IDLE: state_d = S_PLACE;
            S_PLACE: begin
                if (ready) begin
                    state_d = S_TURN_WAIT;
                    vez_d   = 1'b0;
                end
            end
            S_TURN_WAIT: begin
                if (cpu_turn) begin
                    if (timer_q == 8'(CPU_DELAY - 1)) state_d = S_SHOOT;
                    else                              timer_d = timer_q + 8'd1;
                end else if (enter_evt) begin
                    state_d = S_SHOOT;
                end
            end
            S_SHOOT: begin
                if (shoot_ack) begin
                    ultimo_d = hit;
                    state_d  = S_RESULT;
                end else if (timer_q == 8'(ACK_TIMEOUT - 1)) begin
                    ultimo_d = 1'b0;
                    erro_d   = 1'b1;
                    state_d  = S_RESULT;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_RESULT: begin
                if (vez_q) hits1_d = nxt_hits;
                else       hits0_d = nxt_hits;
                if (ultimo_q && (nxt_hits == 5'(TOTAL_HITS))) begin
                    state_d    = S_GAME_OVER;
                    vencedor_d = vez_q;
                end else begin
                    state_d = S_TURN_WAIT;
`ifdef TIRO_EXTRA_EN
                    if (!ultimo_q) vez_d = ~vez_q;
`else
                    vez_d = ~vez_q;
`endif
                end
            end
            S_GAME_OVER: begin
                if (enter_evt) begin
                    state_d    = S_IDLE;
                    hits0_d    = 5'd0;
                    hits1_d    = 5'd0;
                    vez_d      = 1'b0;
                    vencedor_d = 1'b0;
                    ultimo_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Both timed states start counting from zero on entry.
        if (state_d != state_q) timer_d = 8'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            vez_q      <= 1'b0;
            timer_q    <= 8'd0;
            hits0_q    <= 5'd0;
            hits1_q    <= 5'd0;
            ultimo_q   <= 1'b0;
            erro_q     <= 1'b0;
            vencedor_q <= 1'b0;
        end else if (enable) begin
            state_q    <= state_d;
            vez_q      <= vez_d;
            timer_q    <= timer_d;
            hits0_q    <= hits0_d;
            hits1_q    <= hits1_d;
            ultimo_q   <= ultimo_d;
            erro_q     <= erro_d;
            vencedor_q <= vencedor_d;
        end
    end

    // State-decoded outputs follow the asynchronous reset with no clock edge.
    assign place_en      = (state_q == S_PLACE);
    assign shoot_req     = (state_q == S_SHOOT);
    assign atirador      = (state_q == S_SHOOT) & vez_q;
    assign game_over     = (state_q == S_GAME_OVER);
    assign vez           = vez_q;
    assign fase          = state_q;
    assign hits0         = hits0_q;
    assign hits1         = hits1_q;
    assign ultimo_acerto = ultimo_q;
    assign erro          = erro_q;
    assign vencedor      = vencedor_q;

endmodule

// File: tb/tb_controle_partida.sv
module tb_controle_partida;

    localparam int TOTAL_HITS  = 24;
    localparam int CPU_DELAY   = 16;
    localparam int ACK_TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       reset, enable, mode, enter, ready, shoot_ack, hit;
    logic       place_en, shoot_req, atirador, vez, ultimo_acerto, erro, game_over, vencedor;
    logic [2:0] fase;
    logic [4:0] hits0, hits1;

    int checks = 0;
    int errors = 0;

    // reference model of the score state
    logic       exp_vez  = 1'b0;
    int         exp_h0   = 0;
    int         exp_h1   = 0;
    logic       exp_over = 1'b0;
    logic       exp_venc = 1'b0;

    controle_partida #(
        .TOTAL_HITS (TOTAL_HITS),
        .CPU_DELAY  (CPU_DELAY),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mode         (mode),
        .enter        (enter),
        .ready        (ready),
        .shoot_ack    (shoot_ack),
        .hit          (hit),
        .place_en     (place_en),
        .shoot_req    (shoot_req),
        .atirador     (atirador),
        .vez          (vez),
        .fase         (fase),
        .hits0        (hits0),
        .hits1        (hits1),
        .ultimo_acerto(ultimo_acerto),
        .erro         (erro),
        .game_over    (game_over),
        .vencedor     (vencedor)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Human shot: press enter, optionally freeze in SHOOT, ack after w cycles.
    task automatic do_shot(input logic h, input int w, input int frz);
        logic fin;
        enter = 1'b0;
        tick();
        enter = 1'b1;
        check("req_before_shoot", shoot_req, 0);
        tick();
        check("req_on_shoot", shoot_req, 1);
        check("fase_shoot", fase, 3);
        check("atirador", atirador, exp_vez);
        if (frz > 0) begin
            enable = 1'b0;
            repeat (frz) tick();
            check("frozen_req", shoot_req, 1);
            check("frozen_fase", fase, 3);
            enable = 1'b1;
        end
        repeat (w) tick();
        shoot_ack = 1'b1;
        hit       = h;
        tick();
        shoot_ack = 1'b0;
        hit       = 1'b0;
        check("req_after_ack", shoot_req, 0);
        check("fase_result", fase, 4);
        check("ultimo", ultimo_acerto, h);
        check("no_erro", erro, 0);
        if (h) begin
            if (exp_vez) exp_h1++;
            else         exp_h0++;
        end
        fin = h && ((exp_vez ? exp_h1 : exp_h0) == TOTAL_HITS);
        if (fin) begin
            exp_over = 1'b1;
            exp_venc = exp_vez;
        end else begin
`ifdef TIRO_EXTRA_EN
            if (!h) exp_vez = ~exp_vez;
`else
            exp_vez = ~exp_vez;
`endif
        end
        tick();
        check("fase_after", fase, fin ? 5 : 2);
        check("hits0", hits0, exp_h0);
        check("hits1", hits1, exp_h1);
        check("vez", vez, exp_vez);
        check("game_over", game_over, exp_over);
        if (fin) check("vencedor", vencedor, exp_venc);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; mode = 1'b1; enter = 1'b1;
        ready = 1'b0; shoot_ack = 1'b0; hit = 1'b0;
        repeat (3) tick();
        check("rst_fase", fase, 0);
        check("rst_req", shoot_req, 0);
        check("rst_place_en", place_en, 0);
        check("rst_hits0", hits0, 0);
        check("rst_game_over", game_over, 0);
        check("rst_erro", erro, 0);

        // IDLE -> PLACE -> TURN_WAIT
        reset  = 1'b1;
        enable = 1'b1;
        check("idle_fase", fase, 0);
        tick();
        check("place_fase", fase, 1);
        check("place_en_on", place_en, 1);
        repeat (2) tick();
        check("place_hold", fase, 1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("turn_fase", fase, 2);
        check("place_en_off", place_en, 0);
        check("turn_vez", vez, 0);

        // human player 0 hits
        do_shot(1'b1, 2, 0);
        if (exp_vez == 1'b0) do_shot(1'b0, 0, 0);

        // CPU turn: SHOOT exactly CPU_DELAY cycles after TURN_WAIT entry
        mode = 1'b0;
        for (int i = 1; i < CPU_DELAY; i++) begin
            tick();
            enter = (i == 3 || i == 4) ? 1'b0 : 1'b1;
            if (i == 6) check("cpu_ignores_enter", fase, 2);
        end
        check("cpu_wait_last", fase, 2);
        tick();
        check("cpu_shoot_fase", fase, 3);
        check("cpu_atirador", atirador, 1);

        // no ack: timeout
        repeat (ACK_TIMEOUT - 1) tick();
        check("to_still_shoot", fase, 3);
        check("to_no_erro_yet", erro, 0);
        tick();
        check("to_fase_result", fase, 4);
        check("to_erro", erro, 1);
        check("to_ultimo", ultimo_acerto, 0);
        tick();
        exp_vez = ~exp_vez;
        check("to_erro_pulse", erro, 0);
        check("to_fase_turn", fase, 2);
        check("to_hits1", hits1, exp_h1);
        check("to_vez", vez, exp_vez);

        // ack and ready outside their states are ignored
        mode      = 1'b1;
        shoot_ack = 1'b1;
        hit       = 1'b1;
        ready     = 1'b1;
        tick();
        shoot_ack = 1'b0;
        hit       = 1'b0;
        ready     = 1'b0;
        tick();
        check("stray_ack_fase", fase, 2);
        check("stray_ack_hits0", hits0, exp_h0);

        // ack in the same cycle as timeout expiry wins
        do_shot(exp_vez == 1'b0, ACK_TIMEOUT - 1, 0);

        // enter edge during freeze is lost
        enable = 1'b0;
        tick();
        enter = 1'b0;
        repeat (2) tick();
        enter = 1'b1;
        repeat (2) tick();
        enable = 1'b1;
        repeat (3) tick();
        check("frozen_enter_lost", fase, 2);

        // play until player 0 sinks the fleet (first shot also tests freeze)
        for (int i = 0; i < 80 && !exp_over; i++)
            do_shot(exp_vez == 1'b0, 1, (i == 0) ? 4 : 0);
        check("end_game_over", game_over, 1);
        check("end_vencedor", vencedor, 0);
        check("end_fase", fase, 5);

        // enter returns to IDLE and clears the score
        enter = 1'b0;
        tick();
        enter = 1'b1;
        check("go_hold", fase, 5);
        tick();
        check("go_idle", fase, 0);
        check("go_hits0", hits0, 0);
        check("go_hits1", hits1, 0);
        check("go_flag", game_over, 0);
        check("go_vencedor", vencedor, 0);
        check("go_ultimo", ultimo_acerto, 0);
        check("go_vez", vez, 0);

        // asynchronous reset while shoot_req is high
        tick();
        check("replace_fase", fase, 1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        enter = 1'b0;
        tick();
        enter = 1'b1;
        tick();
        check("pre_rst_req", shoot_req, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_req", shoot_req, 0);
        check("async_rst_fase", fase, 0);
        check("async_rst_place", place_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
